// File: rtl/prbs_gen_check_if.sv
// Bundle of generator/checker data and status signals for prbs_gen_check.
// master = link-test driver side, slave = the PRBS block.
interface prbs_gen_check_if #(
  parameter int DATA_W    = 1,
  parameter int ERR_CNT_W = 16
);
  logic [1:0]           mode;
  logic                 gen_en;
  logic                 inj_err;
  logic [DATA_W-1:0]    gen_dout;
  logic                 gen_valid;
  logic [DATA_W-1:0]    chk_din;
  logic                 chk_valid;
  logic                 clr;
  logic                 locked;
  logic [ERR_CNT_W-1:0] err_cnt;
  logic                 err_sat;

  modport master (
    output mode, gen_en, inj_err, chk_din, chk_valid, clr,
    input  gen_dout, gen_valid, locked, err_cnt, err_sat
  );
  modport slave (
    input  mode, gen_en, inj_err, chk_din, chk_valid, clr,
    output gen_dout, gen_valid, locked, err_cnt, err_sat
  );
endinterface

// File: rtl/prbs_gen_check.sv
// PRBS7/15/23/31 word generator and self-synchronising checker with lock FSM.
// Define PRBS_ERR_INJECT_EN to enable single-bit error injection on the generator.
module prbs_gen_check #(
  parameter int DATA_W     = 1,
  parameter int ERR_CNT_W  = 16,
  parameter int LOCK_GOOD  = 16,
  parameter int UNLOCK_BAD = 4
) (
  input logic             clk,
  input logic             rst_n,
  prbs_gen_check_if.slave bus
);
  localparam int GW = $clog2(LOCK_GOOD + 1);
  localparam int BW = $clog2(UNLOCK_BAD + 1);
  localparam int PW = $clog2(DATA_W + 1);
  localparam logic [ERR_CNT_W:0] CNT_MAX = {1'b0, {ERR_CNT_W{1'b1}}};

  typedef enum logic {UNLOCKED, LOCKED} lock_e;

  // Feedback bit for one step; s[0] is the most recent bit.
  function automatic logic fb(input logic [30:0] s, input logic [1:0] m);
    case (m)
      2'd0:    fb = s[6]  ^ s[5];
      2'd1:    fb = s[14] ^ s[13];
      2'd2:    fb = s[22] ^ s[17];
      default: fb = s[30] ^ s[27];
    endcase
  endfunction

  logic [30:0]          g, g_nxt, h, h_nxt;
  logic [1:0]           mode_q;
  logic                 mode_chg;
  logic [DATA_W-1:0]    gen_word, flip, err_vec, gen_dout;
  logic                 gen_valid, locked, err_sat;
  logic [PW-1:0]        pop;
  logic [ERR_CNT_W:0]   sum;
  logic [ERR_CNT_W-1:0] err_cnt;
  logic [GW-1:0]        good_cnt;
  logic [BW-1:0]        bad_cnt;
  lock_e                state;

  assign mode_chg = (bus.mode != mode_q);

  always_comb begin
    g_nxt    = g;
    gen_word = '0;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      gen_word[i] = fb(g_nxt, bus.mode);
      g_nxt       = {g_nxt[29:0], gen_word[i]};
    end
  end

  // Prediction for later bits of a word already sees earlier received bits.
  always_comb begin
    h_nxt   = h;
    err_vec = '0;
    pop     = '0;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      err_vec[i] = bus.chk_din[i] ^ fb(h_nxt, bus.mode);
      h_nxt      = {h_nxt[29:0], bus.chk_din[i]};
    end
    for (int i = 0; i < DATA_W; i++) pop = pop + PW'(err_vec[i]);
    sum = {1'b0, err_cnt} + (ERR_CNT_W + 1)'(pop);
  end

`ifdef PRBS_ERR_INJECT_EN
  logic inj_pend;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       inj_pend <= 1'b0;
    else if (bus.gen_en && !mode_chg) inj_pend <= 1'b0;
    else if (bus.inj_err)             inj_pend <= 1'b1;
  end

  always_comb begin
    flip         = '0;
    flip[DATA_W-1] = bus.inj_err | inj_pend;
  end
`else
  logic unused_inj;
  assign unused_inj = bus.inj_err;
  assign flip       = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      g         <= 31'd1;
      h         <= '0;
      mode_q    <= 2'd0;
      state     <= UNLOCKED;
      good_cnt  <= '0;
      bad_cnt   <= '0;
      gen_dout  <= '0;
      gen_valid <= 1'b0;
      locked    <= 1'b0;
      err_cnt   <= '0;
      err_sat   <= 1'b0;
    end else begin
      gen_valid <= 1'b0;
      // A mode change restarts both ends; the word in flight is dropped.
      if (mode_chg) begin
        mode_q   <= bus.mode;
        g        <= 31'd1;
        h        <= '0;
        good_cnt <= '0;
        bad_cnt  <= '0;
        state    <= UNLOCKED;
        locked   <= 1'b0;
      end else begin
        if (bus.gen_en) begin
          g         <= g_nxt;
          gen_dout  <= gen_word ^ flip;
          gen_valid <= 1'b1;
        end
        if (bus.chk_valid) begin
          h <= h_nxt;
          case (state)
            UNLOCKED: begin
              if (|err_vec) good_cnt <= '0;
              else if (good_cnt == GW'(LOCK_GOOD - 1)) begin
                state    <= LOCKED;
                locked   <= 1'b1;
                good_cnt <= '0;
                bad_cnt  <= '0;
              end else good_cnt <= good_cnt + 1'b1;
            end
            default: begin
              if (!(|err_vec)) bad_cnt <= '0;
              else if (bad_cnt == BW'(UNLOCK_BAD - 1)) begin
                state    <= UNLOCKED;
                locked   <= 1'b0;
                bad_cnt  <= '0;
                good_cnt <= '0;
              end else bad_cnt <= bad_cnt + 1'b1;
            end
          endcase
        end
      end
      // Only words checked while already locked contribute errors.
      if (bus.clr) begin
        err_cnt <= '0;
        err_sat <= 1'b0;
      end else if (!mode_chg && bus.chk_valid && state == LOCKED) begin
        if (sum >= CNT_MAX) begin
          err_cnt <= '1;
          err_sat <= 1'b1;
        end else err_cnt <= sum[ERR_CNT_W-1:0];
      end
    end
  end

  assign bus.gen_dout  = gen_dout;
  assign bus.gen_valid = gen_valid;
  assign bus.locked    = locked;
  assign bus.err_cnt   = err_cnt;
  assign bus.err_sat   = err_sat;
endmodule

// File: tb/tb_prbs_gen_check.sv
// Loopback bench for prbs_gen_check: generated words scoreboarded against a bit-serial
// reference, checker exercised with bit flips, inverted words, mode switches and reset.
module tb_prbs_gen_check;
  localparam int DW = 8;
  localparam int EW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] corrupt = '0;
  logic          chk_on = 1'b0;

  prbs_gen_check_if #(.DATA_W(DW), .ERR_CNT_W(EW)) bus ();

  prbs_gen_check #(.DATA_W(DW), .ERR_CNT_W(EW), .LOCK_GOOD(16), .UNLOCK_BAD(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  assign bus.chk_din   = bus.gen_dout ^ corrupt;
  assign bus.chk_valid = bus.gen_valid & chk_on;

  always #5 clk = ~clk;

  int            n_chk = 0;
  int            n_fail = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] last_exp = '0;
  bit            hist[$];
  int            n_tap = 7;
  int            t_tap = 6;
  logic [1:0]    mode_m = 2'd0;
  logic          pend_m = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference history: last entry is the newest bit; seed 1 means one prior '1' bit.
  function automatic void model_seed(input logic [1:0] m);
    hist.delete();
    for (int i = 0; i < 30; i++) hist.push_back(1'b0);
    hist.push_back(1'b1);
    case (m)
      2'd0:    begin n_tap = 7;  t_tap = 6;  end
      2'd1:    begin n_tap = 15; t_tap = 14; end
      2'd2:    begin n_tap = 23; t_tap = 18; end
      default: begin n_tap = 31; t_tap = 28; end
    endcase
  endfunction

  function automatic logic [DW-1:0] model_word();
    logic [DW-1:0] w;
    bit            b;
    w = '0;
    for (int i = DW - 1; i >= 0; i--) begin
      b    = hist[hist.size() - n_tap] ^ hist[hist.size() - t_tap];
      w[i] = b;
      hist.push_back(b);
    end
    while (hist.size() > 64) void'(hist.pop_front());
    return w;
  endfunction

  task automatic cycle();
    logic [DW-1:0] w;
    logic          chg, inj_now;
    chg     = (bus.mode != mode_m);
    inj_now = 1'b0;
`ifdef PRBS_ERR_INJECT_EN
    inj_now = bus.inj_err | pend_m;
`endif
    if (chg) begin
      mode_m = bus.mode;
      model_seed(bus.mode);
    end else if (bus.gen_en) begin
      w = model_word();
      if (inj_now) w[DW-1] = ~w[DW-1];
      exp_q.push_back(w);
    end
`ifdef PRBS_ERR_INJECT_EN
    if (!chg && bus.gen_en) pend_m = 1'b0;
    else if (bus.inj_err)   pend_m = 1'b1;
`endif
    @(posedge clk);
    #1;
    if (bus.gen_valid) begin
      if (exp_q.size() == 0) check("gen_unexpected", 32'd1, 32'd0);
      else begin
        last_exp = exp_q.pop_front();
        check("gen_word", 32'(bus.gen_dout), 32'(last_exp));
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic wait_lock(input string tag, input int max);
    int n;
    n = 0;
    while (!bus.locked && n < max) begin
      cycle();
      n++;
    end
    check(tag, 32'(bus.locked), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    bus.mode    = 2'd0;
    bus.gen_en  = 1'b0;
    bus.inj_err = 1'b0;
    bus.clr     = 1'b0;
    model_seed(2'd0);
    #12;
    check("rst_dout",   32'(bus.gen_dout),  32'd0);
    check("rst_valid",  32'(bus.gen_valid), 32'd0);
    check("rst_locked", 32'(bus.locked),    32'd0);
    check("rst_cnt",    32'(bus.err_cnt),   32'd0);
    check("rst_sat",    32'(bus.err_sat),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // PRBS7 loopback
    bus.gen_en = 1'b1;
    chk_on     = 1'b1;
    cycle();
    check("prbs7_first", 32'(bus.gen_dout), 32'h06);
    wait_lock("prbs7_lock", 30);
    run(200);
    check("prbs7_cnt", 32'(bus.err_cnt), 32'd0);
    check("prbs7_locked", 32'(bus.locked), 32'd1);

    // single received-bit flips: 3 bit errors each, saturating at 15
    for (int i = 1; i <= 6; i++) begin
      corrupt = 8'h10;
      cycle();
      corrupt = '0;
      run(20);
      check("flip_cnt", 32'(bus.err_cnt), (i < 6) ? 32'(3 * i) : 32'd15);
      check("flip_locked", 32'(bus.locked), 32'd1);
    end
    check("sat_set", 32'(bus.err_sat), 32'd1);

    // clr beats an errored word in the same cycle
    corrupt = 8'h10;
    bus.clr = 1'b1;
    cycle();
    bus.clr = 1'b0;
    corrupt = '0;
    check("clr_cnt", 32'(bus.err_cnt), 32'd0);
    check("clr_sat", 32'(bus.err_sat), 32'd0);
    run(20);
    check("post_clr_cnt", 32'(bus.err_cnt), 32'd2);

    // switch to PRBS15
    bus.mode = 2'd1;
    cycle();
    check("m1_locked", 32'(bus.locked), 32'd0);
    check("m1_cnt", 32'(bus.err_cnt), 32'd2);
    wait_lock("prbs15_lock", 40);
    run(50);
    check("prbs15_cnt", 32'(bus.err_cnt), 32'd2);

    // inverted words: unlock after the 4th
    bus.clr = 1'b1;
    cycle();
    bus.clr = 1'b0;
    check("clr2_cnt", 32'(bus.err_cnt), 32'd0);
    corrupt = '1;
    cycle();
    check("inv1_cnt", 32'(bus.err_cnt), 32'd8);
    check("inv1_locked", 32'(bus.locked), 32'd1);
    run(2);
    check("inv3_locked", 32'(bus.locked), 32'd1);
    cycle();
    check("inv4_locked", 32'(bus.locked), 32'd0);
    check("inv4_cnt", 32'(bus.err_cnt), 32'd15);
    check("inv4_sat", 32'(bus.err_sat), 32'd1);
    bus.clr = 1'b1;
    cycle();
    bus.clr = 1'b0;
    run(3);
    check("unlocked_cnt", 32'(bus.err_cnt), 32'd0);
    corrupt = '0;
    wait_lock("prbs15_relock", 40);
    run(50);
    check("relock_cnt", 32'(bus.err_cnt), 32'd0);

    // switch to PRBS31 while locked
    bus.mode = 2'd3;
    cycle();
    check("m3_locked", 32'(bus.locked), 32'd0);
    check("m3_cnt", 32'(bus.err_cnt), 32'd0);
    cycle();
    check("prbs31_valid", 32'(bus.gen_valid), 32'd1);
    check("prbs31_first", 32'(bus.gen_dout), 32'h00);
    wait_lock("prbs31_lock", 30);
    run(1250);
    check("prbs31_cnt", 32'(bus.err_cnt), 32'd0);
    check("prbs31_locked", 32'(bus.locked), 32'd1);

    // generator pause: output holds, checker idles
    bus.gen_en = 1'b0;
    run(3);
    check("gap_valid", 32'(bus.gen_valid), 32'd0);
    check("gap_hold", 32'(bus.gen_dout), 32'(last_exp));
    bus.gen_en = 1'b1;
    run(20);
    check("gap_locked", 32'(bus.locked), 32'd1);
    check("gap_cnt", 32'(bus.err_cnt), 32'd0);

`ifdef PRBS_ERR_INJECT_EN
    bus.inj_err = 1'b1;
    cycle();
    bus.inj_err = 1'b0;
    run(40);
    check("inj_cnt", 32'(bus.err_cnt), 32'd3);
    check("inj_locked", 32'(bus.locked), 32'd1);
    bus.gen_en  = 1'b0;
    bus.inj_err = 1'b1;
    cycle();
    bus.inj_err = 1'b0;
    cycle();
    bus.gen_en = 1'b1;
    run(40);
    check("pend_cnt", 32'(bus.err_cnt), 32'd6);
    check("pend_locked", 32'(bus.locked), 32'd1);
`else
    bus.inj_err = 1'b1;
    cycle();
    bus.inj_err = 1'b0;
    run(40);
    check("noinj_cnt", 32'(bus.err_cnt), 32'd0);
    check("noinj_locked", 32'(bus.locked), 32'd1);
`endif

    // asynchronous reset mid-stream
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_dout",   32'(bus.gen_dout),  32'd0);
    check("mid_rst_valid",  32'(bus.gen_valid), 32'd0);
    check("mid_rst_locked", 32'(bus.locked),    32'd0);
    check("mid_rst_cnt",    32'(bus.err_cnt),   32'd0);
    exp_q.delete();
    mode_m = 2'd0;
    pend_m = 1'b0;
    model_seed(2'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_lock("post_rst_lock", 40);
    check("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
